alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, operand/result width in bits (legal 4..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operands/opcode presented.
REQ-005 SHALL have port: in_ready  output  1  block accepts operation this cycle.
REQ-006 SHALL have port: a  input  WIDTH  operand A.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: sel  input  3  opcode.
REQ-009 SHALL have port: out_valid  output  1  result/flags valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port: result  output  WIDTH  registered result.
REQ-012 SHALL have port: flags  output  4  registered {N,Z,C,V}, bit3 = N.

Function
REQ-013 SHALL decode sel: 0 pass B; 1 MUL (REQ-030) or zero; 2 A+B; 3 A-B; 4 A&B; 5 A|B; 6 A^B; 7 ~B.
REQ-014 SHALL accept an operation on a cycle where in_valid && in_ready (transfer); inputs otherwise ignored.
REQ-015 SHALL implement states IDLE, BUSY, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; transfer of single-cycle op -> DONE; transfer of MUL (enabled) -> BUSY.
REQ-017 BUSY: in_ready=0, out_valid=0; after exactly WIDTH cycles in BUSY -> DONE.
REQ-018 DONE: out_valid=1; in_ready=out_ready; result and flags held stable while out_ready=0.
REQ-019 DONE with out_ready=1: if in_valid, new op accepted same cycle (single-cycle -> stay DONE with new result next cycle; MUL -> BUSY); else -> IDLE.
REQ-020 Single-cycle op latency SHALL be 1 cycle: transfer on edge N, out_valid with result at edge N+1; sustained throughput 1 op/cycle when out_ready held high.
REQ-021 Add SHALL compute A+B modulo 2^WIDTH; C = carry out of MSB; V = signed overflow (operands same sign, result sign differs).
REQ-022 Subtract SHALL compute A + ~B + 1; C = carry out (1 = no borrow, A>=B unsigned); V = signed overflow of A-B.
REQ-023 Ops 0,4,5,6,7 and zero-op SHALL set C=0, V=0.
REQ-024 For all ops N = result[WIDTH-1], Z = (result == 0).
REQ-025 in_valid deasserted in any state SHALL not alter state except as in REQ-019.
REQ-026 sel values and operands SHALL be captured at transfer; changes during BUSY/DONE have no effect.

Reset
REQ-027 reset_n low SHALL asynchronously force state IDLE, result=0, flags=0, out_valid=0, internal multiply registers/counter=0.
REQ-028 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation; no result is delivered after release.
REQ-029 in_ready SHALL be 1 from first cycle after reset_n release.

Configuration
REQ-030 Macro ALU_SEQ_MUL_EN defined: sel=1 is unsigned shift-add multiply, one partial product per BUSY cycle, WIDTH BUSY cycles; result = low WIDTH bits of product; C = 1 iff high WIDTH bits nonzero; V=0; latency WIDTH+1 cycles transfer-to-out_valid.
REQ-031 Macro ALU_SEQ_MUL_EN undefined: no multiplier logic, no BUSY entry; sel=1 returns result 0, flags {0,1,0,0}, latency 1.

Verification (WIDTH=16)
REQ-032 Add: a=16'h7FFF, b=16'h0001, sel=2 -> next cycle result=16'h8000, flags N=1 Z=0 C=0 V=1.
REQ-033 Sub: a=16'h0003, b=16'h0005, sel=3 -> result=16'hFFFE, N=1 Z=0 C=0 V=0; a=b=16'h1234 -> result 0, Z=1, C=1.
REQ-034 Backpressure: op accepted, out_ready=0 for 5 cycles -> out_valid held, result/flags unchanged, in_ready=0; out_ready=1 with in_valid=1 -> new op accepted, next result next cycle.
REQ-035 Throughput: 8 back-to-back ops sel=4..7 with out_ready=1 -> 8 results on 8 consecutive cycles, correct values.
REQ-036 With ALU_SEQ_MUL_EN: a=16'h0100, b=16'h0100, sel=1 -> out_valid 17 cycles after transfer, result=0, C=1, Z=1; a=3, b=5 -> result 15, C=0; without macro sel=1 -> result 0, Z=1, 1-cycle.
REQ-037 Reset: reset_n low 3 cycles after MUL transfer -> immediately out_valid=0, result=0, flags=0; after release in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_seq.sv
// Sequenced ALU with valid/ready handshake on both sides and registered result/flags.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier for sel=1.
//
//   state  | meaning
//   IDLE   | nothing held, ready for a new operation
//   BUSY   | multiply in progress, one partial product per cycle
//   DONE   | result/flags presented, waiting for the consumer
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic             transfer;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [WIDTH:0]   add_sum, sub_sum;

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_mul;

    assign is_mul = (sel == 3'd1);
`endif

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    // Single-cycle datapath; subtract is A + ~B + 1 so C means "no borrow"
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (sel)
            3'd0: alu_res = b;
            3'd2: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            3'd3: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            3'd4: alu_res = a & b;
            3'd5: alu_res = a | b;
            3'd6: alu_res = a ^ b;
            3'd7: alu_res = ~b;
            default: alu_res = '0;
        endcase
    end

    assign transfer = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (transfer) begin
`ifdef ALU_SEQ_MUL_EN
                    if (is_mul) begin
                        state_d  = S_BUSY;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                    end else begin
                        state_d  = S_DONE;
                        result_d = alu_res;
                        flags_d  = mk_flags(alu_res, alu_c, alu_v);
                    end
`else
                    state_d  = S_DONE;
                    result_d = alu_res;
                    flags_d  = mk_flags(alu_res, alu_c, alu_v);
`endif
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
                acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_DONE;
                    result_d = acc_d[WIDTH-1:0];
                    flags_d  = mk_flags(acc_d[WIDTH-1:0], |acc_d[2*WIDTH-1:WIDTH], 1'b0);
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
        out_valid = (state_q == S_DONE);
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16); multiplier expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [2:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int tests  = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [2:0] ts);
        @(negedge clk);
        in_valid = v;
        a        = ta;
        b        = tb_;
        sel      = ts;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sel       = '0;
        out_ready = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== 16'h0 || flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b result=%h flags=%b, want 0/0000/0000",
                     out_valid, result, flags);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    // one single-cycle op from IDLE; result must be present right after the transfer edge
    task automatic one_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [2:0] ts, input logic [W-1:0] exp_r, input logic [3:0] exp_f);
        drive(1'b1, ta, tb_, ts);
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || result !== exp_r || flags !== exp_f) begin
            errors++;
            $display("FAIL %s: out_valid=%b result=%h flags=%b, want 1/%h/%b",
                     name, out_valid, result, flags, exp_r, exp_f);
        end
        idle_cycles(1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_add;
        out_ready = 1'b1;
        one_op("add_ovf",   16'h7FFF, 16'h0001, 3'd2, 16'h8000, 4'b1001);
        one_op("add_carry", 16'hFFFF, 16'h0001, 3'd2, 16'h0000, 4'b0110);
    endtask

    task automatic test_sub;
        one_op("sub_borrow", 16'h0003, 16'h0005, 3'd3, 16'hFFFE, 4'b1000);
        one_op("sub_equal",  16'h1234, 16'h1234, 3'd3, 16'h0000, 4'b0110);
        one_op("sub_ovf",    16'h8000, 16'h0001, 3'd3, 16'h7FFF, 4'b0011);
    endtask

    task automatic test_logic;
        one_op("pass_b", 16'hF0F0, 16'hCC33, 3'd0, 16'hCC33, 4'b1000);
        one_op("and",    16'hF0F0, 16'hCC33, 3'd4, 16'hC030, 4'b1000);
        one_op("or",     16'hF0F0, 16'hCC33, 3'd5, 16'hFCF3, 4'b1000);
        one_op("xor",    16'hF0F0, 16'hCC33, 3'd6, 16'h3CC3, 4'b0000);
        one_op("not_b",  16'hF0F0, 16'hCC33, 3'd7, 16'h33CC, 4'b0000);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 16'h0002, 3'd2);
        @(posedge clk);
        // the next op waits on the inputs and must be ignored while stalled
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || result !== 16'h0003 || flags !== 4'b0000 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b result=%h flags=%b in_ready=%b, want 1/0003/0000/0",
                         i, out_valid, result, flags, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_ready: in_ready=%b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || result !== 16'h0000 || flags !== 4'b0110) begin
            errors++;
            $display("FAIL backpressure_next: out_valid=%b result=%h flags=%b, want 1/0000/0110",
                     out_valid, result, flags);
        end
        idle_cycles(1);
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_idle: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] va [8];
        logic [W-1:0] vb [8];
        logic [2:0]   vs [8];
        logic [W-1:0] er [8];
        logic [3:0]   ef [8];
        va = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
        vb = '{16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h5555, 16'h5555, 16'h5555, 16'h5555};
        vs = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
        er = '{16'h000F, 16'h0FFF, 16'h0FF0, 16'hF0F0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hAAAA};
        ef = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, va[i], vb[i], vs[i]);
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || result !== er[i] || flags !== ef[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: out_valid=%b result=%h flags=%b, want 1/%h/%b",
                         i, out_valid, result, flags, er[i], ef[i]);
            end
        end
        idle_cycles(1);
        @(posedge clk);
        #1;
    endtask

`ifdef ALU_SEQ_MUL_EN
    // latency counted in cycles including the transfer cycle: 16 edges after the transfer edge
    task automatic mul_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] exp_r, input logic [3:0] exp_f);
        int n;
        out_ready = 1'b1;
        drive(1'b1, ta, tb_, 3'd1);
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: out_valid=%b in_ready=%b, want 0/0", name, out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        sel      = 3'd2;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        tests++;
        if (n + 1 != 17) begin
            errors++;
            $display("FAIL %s_latency: latency=%0d cycles, want 17", name, n + 1);
        end
        tests++;
        if (result !== exp_r || flags !== exp_f) begin
            errors++;
            $display("FAIL %s_value: result=%h flags=%b, want %h/%b", name, result, flags, exp_r, exp_f);
        end
        idle_cycles(1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul;
        mul_op("mul_big",   16'h0100, 16'h0100, 16'h0000, 4'b0110);
        mul_op("mul_small", 16'h0003, 16'h0005, 16'h000F, 4'b0000);
        mul_op("mul_mixed", 16'h1234, 16'h0011, 16'h3574, 4'b0010);
    endtask
`else
    task automatic test_mul;
        out_ready = 1'b1;
        one_op("mul_disabled", 16'h1234, 16'h5678, 3'd1, 16'h0000, 4'b0100);
    endtask
`endif

    task automatic test_reset_abort;
        // abort while DONE is stalled
        out_ready = 1'b0;
        drive(1'b1, 16'h0010, 16'h0020, 3'd2);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== 16'h0 || flags !== 4'h0) begin
            errors++;
            $display("FAIL abort_done: out_valid=%b result=%h flags=%b, want 0/0000/0000",
                     out_valid, result, flags);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        // abort three cycles into a multiply
        drive(1'b1, 16'h0100, 16'h0100, 3'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== 16'h0 || flags !== 4'h0) begin
            errors++;
            $display("FAIL abort_busy: out_valid=%b result=%h flags=%b, want 0/0000/0000",
                     out_valid, result, flags);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
`endif
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: in_ready=%b, want 1", in_ready);
        end
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_stale[%0d]: out_valid=%b result=%h, want out_valid 0", i, out_valid, result);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_backpressure();
        test_back_to_back();
        test_mul();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
